uart_receiver: RTL and testbench

//   8N1 UART receive stage. Sits downstream of the transmitter and consumes its tx line.

---
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: 8N1 UART receive stage with a 2-flop input synchroniser, mid-bit start
// validation, LSB-first centre sampling, stop-bit check and one-cycle valid/frame_err strobes.
module uart_receiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  logic               rx_meta;
  logic               rx_s;
  logic               armed;
  logic [CNT_W-1:0]   clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  // Sync flops reset to the idle (high) line level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          // A start edge is only honoured once the line has been seen idle, so a break after
          // a framing error cannot retrigger reception.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver: randomized frame stimulus with a queue scoreboard and a decoupled monitor.
module tb_uart_receiver;
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;
  localparam int TOL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] byte_v;
    int         start;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] held      = 8'h00;
  int         checks    = 0;
  int         errors    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one full frame starting at the current negedge; returns at the negedge after the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    exp_t e;
    rx      = 1'b0;
    e.start = cyc;
    e.ferr  = !stop;
    e.byte_v = stop ? b : last_good;
    if (stop) last_good = b;
    sb.push_back(e);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every strobe and checks data is held between strobes.
  initial begin
    bit   prev;
    exp_t e;
    int   lat;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (valid || frame_err) begin
          check("strobe_exclusive", {31'd0, valid && frame_err}, 32'd0);
          check("strobe_not_consecutive", {31'd0, prev}, 32'd0);
          check("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("strobe_kind_frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            check("strobe_data", {24'd0, data}, {24'd0, e.byte_v});
            lat = cyc - e.start;
            checks++;
            if (lat < LAT - TOL || lat > LAT + TOL) begin
              errors++;
              $display("FAIL latency: got %0d cycles expected %0d +/-%0d", lat, LAT, TOL);
            end
            if (valid) held = e.byte_v;
          end
        end else begin
          check("data_hold", {24'd0, data}, {24'd0, held});
        end
        prev = valid || frame_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string      msg;
    logic [7:0] b;
    bit         stop;
    int         gap;
    msg = "Hello, World!";

    // Reset and long idle line
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(1000);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, data}, 32'h00);

    // Single byte
    send_frame(8'h48, 1'b1);
    idle(2);
    check("byte_48", {24'd0, data}, 32'h48);
    idle(2 * CPB);

    // Back-to-back string, no idle gap between frames
    for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
    idle(2 * CPB);
    check("string_last", {24'd0, data}, {24'd0, msg[msg.len()-1]});

    // Short glitch: busy rises, then drops at the start-bit check
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (HALF - 2) @(negedge clk);
    check("glitch_busy_still_high", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    idle(2 * CPB);

    // Framing error, then a two-frame break, then a good byte
    send_frame(8'h55, 1'b0);
    check("ferr_data_kept", {24'd0, data}, {24'd0, last_good});
    repeat (20 * CPB) @(negedge clk);
    check("break_not_busy", {31'd0, busy}, 32'd0);
    idle(2 * CPB);
    send_frame(8'hA3, 1'b1);
    idle(2);
    check("after_break_A3", {24'd0, data}, 32'hA3);
    idle(2 * CPB);

    // Reset in the middle of 0x6C (at data bit 4)
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    b = 8'h6C;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_data", {24'd0, data}, 32'h00);
    sb.delete();
    last_good = 8'h00;
    held      = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2 * CPB);
    send_frame(8'h21, 1'b1);
    idle(2);
    check("after_reset_21", {24'd0, data}, 32'h21);
    idle(CPB);

    // Randomized frames with occasional bad stop bits and random idle gaps
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      gap = stop ? int'($urandom_range(0, 2 * CPB)) : CPB + int'($urandom_range(0, CPB));
      idle(gap);
    end

    idle(3 * CPB);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
